// File: rtl/usr_pkg.sv
// rtl/usr_pkg.sv - op-code and FSM state types for uni_shift_reg_seq
package usr_pkg;

    typedef enum logic [2:0] {
        OP_HOLD  = 3'b000,
        OP_SHR   = 3'b001,
        OP_SHL   = 3'b010,
        OP_LOAD  = 3'b011,
        OP_ASR   = 3'b100,
        OP_ROR   = 3'b101,
        OP_ROL   = 3'b110,
        OP_CLEAR = 3'b111
    } usr_op_t;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } usr_state_t;

    // Counted ops honour cmd_cnt; the rest always complete in one cycle.
    function automatic logic is_counted(input usr_op_t op);
        logic r;
        r = 1'b0;
        case (op)
            OP_SHR, OP_SHL, OP_ASR, OP_ROR, OP_ROL: r = 1'b1;
            default:                                r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/usr_step.sv
// rtl/usr_step.sv - single-step next-value function; rotates built only with USR_ROTATE_EN
module usr_step
    import usr_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  usr_op_t          op,
    input  logic [WIDTH-1:0] q,
    input  logic             ser_r,
    input  logic             ser_l,
    input  logic [WIDTH-1:0] cmd_pin,
    output logic [WIDTH-1:0] q_next
);

    always_comb begin
        q_next = q;
        case (op)
            OP_SHR:   q_next = {ser_r, q[WIDTH-1:1]};
            OP_SHL:   q_next = {q[WIDTH-2:0], ser_l};
            OP_LOAD:  q_next = cmd_pin;
            OP_ASR:   q_next = {q[WIDTH-1], q[WIDTH-1:1]};
`ifdef USR_ROTATE_EN
            OP_ROR:   q_next = {q[0], q[WIDTH-1:1]};
            OP_ROL:   q_next = {q[WIDTH-2:0], q[WIDTH-1]};
`endif
            OP_CLEAR: q_next = '0;
            default:  q_next = q;
        endcase
    end

endmodule

// File: rtl/uni_shift_reg_seq.sv
// rtl/uni_shift_reg_seq.sv - command-driven multi-step shift register (optional USR_ROTATE_EN)
module uni_shift_reg_seq
    import usr_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [CNT_W-1:0] cmd_cnt,
    input  logic [WIDTH-1:0] cmd_pin,
    input  logic             ser_r,
    input  logic             ser_l,
    output logic [WIDTH-1:0] q,
    output logic             so_l,
    output logic             so_r,
    output logic             busy,
    output logic             done
);

    usr_state_t       state;
    usr_op_t          op_l;
    usr_op_t          cur_op;
    logic [CNT_W-1:0] rem;
    logic [WIDTH-1:0] q_next;

    // In IDLE the step uses the incoming op; in SHIFT the latched one.
    assign cur_op = (state == IDLE) ? usr_op_t'(cmd_op) : op_l;

    usr_step #(.WIDTH(WIDTH)) u_step (
        .op      (cur_op),
        .q       (q),
        .ser_r   (ser_r),
        .ser_l   (ser_l),
        .cmd_pin (cmd_pin),
        .q_next  (q_next)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q     <= '0;
            state <= IDLE;
            rem   <= '0;
            op_l  <= OP_HOLD;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        if (!is_counted(cur_op)) begin
                            q    <= q_next;
                            done <= 1'b1;
                        end else if (cmd_cnt == '0) begin
                            done <= 1'b1;
                        end else begin
                            q <= q_next;
                            if (cmd_cnt == CNT_W'(1)) begin
                                done <= 1'b1;
                            end else begin
                                rem   <= cmd_cnt - CNT_W'(1);
                                op_l  <= cur_op;
                                state <= SHIFT;
                            end
                        end
                    end
                end
                SHIFT: begin
                    q   <= q_next;
                    rem <= rem - CNT_W'(1);
                    if (rem == CNT_W'(1)) begin
                        state <= IDLE;
                        done  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign cmd_ready = (state == IDLE);
    assign busy      = (state == SHIFT);
    assign so_l      = q[WIDTH-1];
    assign so_r      = q[0];

endmodule

// File: tb/tb_uni_shift_reg_seq.sv
// tb/tb_uni_shift_reg_seq.sv - directed and randomized check of uni_shift_reg_seq against a step-count model
module tb_uni_shift_reg_seq;

    localparam int W  = 8;
    localparam int CW = $clog2(W) + 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [2:0]    cmd_op = 3'd0;
    logic [CW-1:0] cmd_cnt = '0;
    logic [W-1:0]  cmd_pin = '0;
    logic          ser_r = 1'b0;
    logic          ser_l = 1'b0;
    logic [W-1:0]  q;
    logic          so_l, so_r, busy, done;

    int vectors = 0;
    int miscompares = 0;

    uni_shift_reg_seq #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_cnt(cmd_cnt), .cmd_pin(cmd_pin),
        .ser_r(ser_r), .ser_l(ser_l), .q(q), .so_l(so_l), .so_r(so_r),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // One step of each op computed with integer arithmetic.
    function automatic logic [W-1:0] mstep(input int op, input logic [W-1:0] v,
                                           input bit sr, input bit sl, input logic [W-1:0] pin);
        int x, top;
        x   = int'(v);
        top = 2 ** (W - 1);
        case (op)
            1: return W'((x / 2) + (sr ? top : 0));
            2: return W'((x * 2 + int'(sl)) % (2 ** W));
            3: return pin;
            4: return W'((x / 2) + (x >= top ? top : 0));
`ifdef USR_ROTATE_EN
            5: return W'((x / 2) + (x % 2) * top);
            6: return W'((x * 2) % (2 ** W) + x / top);
`endif
            7: return '0;
            default: return v;
        endcase
    endfunction

    // Model: expected q, steps still owed by the current command, and done.
    logic [W-1:0] m_q = '0;
    int           m_left = 0;
    int           m_op = 0;
    bit           m_done = 1'b0;
    bit           armed = 1'b0;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_q = '0; m_left = 0; m_done = 1'b0; armed = 1'b1;
        end else if (m_left > 0) begin
            m_q = mstep(m_op, m_q, ser_r, ser_l, cmd_pin);
            m_left--;
            m_done = (m_left == 0);
        end else if (cmd_valid) begin
            int op, n;
            op = int'(cmd_op);
            n  = int'(cmd_cnt);
            if (op inside {1, 2, 4, 5, 6}) begin
                if (n > 0) m_q = mstep(op, m_q, ser_r, ser_l, cmd_pin);
                m_op   = op;
                m_left = (n > 0) ? n - 1 : 0;
                m_done = (m_left == 0);
            end else begin
                m_q    = mstep(op, m_q, ser_r, ser_l, cmd_pin);
                m_done = 1'b1;
            end
        end else begin
            m_done = 1'b0;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (armed) begin
            chk("model_q", 32'(q), 32'(m_q));
            chk("model_so_l", 32'(so_l), 32'(m_q[W-1]));
            chk("model_so_r", 32'(so_r), 32'(m_q[0]));
            chk("model_busy", 32'(busy), 32'(m_left > 0));
            chk("model_ready", 32'(cmd_ready), 32'(m_left == 0));
            chk("model_done", 32'(done), 32'(m_done));
        end
    end

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic issue(input logic [2:0] op, input int cnt, input logic [W-1:0] pin);
        cmd_valid = 1'b1; cmd_op = op; cmd_cnt = CW'(cnt); cmd_pin = pin;
        cyc();
        cmd_valid = 1'b0;
    endtask

    initial begin
        @(negedge clk);
        rst_n = 1'b0;
        cyc(); cyc();
        chk("rst_q", 32'(q), 32'h00);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_done", 32'(done), 32'h0);
        chk("rst_ready", 32'(cmd_ready), 32'h1);
        rst_n = 1'b1;

        issue(3'b011, 0, 8'hB5);
        chk("load_q", 32'(q), 32'hB5);
        chk("load_done", 32'(done), 32'h1);
        chk("load_busy", 32'(busy), 32'h0);
        cyc();
        chk("load_done_drop", 32'(done), 32'h0);

        ser_l = 1'b1;
        issue(3'b010, 3, 8'h00);
        cmd_valid = 1'b1; cmd_op = 3'b111;
        chk("shl_q1", 32'(q), 32'h6B);
        chk("shl_busy1", 32'(busy), 32'h1);
        cyc();
        cmd_valid = 1'b0;
        chk("shl_q2", 32'(q), 32'hD7);
        chk("shl_busy2", 32'(busy), 32'h1);
        cyc();
        chk("shl_q3", 32'(q), 32'hAF);
        chk("shl_done", 32'(done), 32'h1);
        chk("shl_busy3", 32'(busy), 32'h0);

        issue(3'b011, 0, 8'h90);
        issue(3'b100, 2, 8'h00);
        chk("asr_q1", 32'(q), 32'hC8);
        cyc();
        chk("asr_q2", 32'(q), 32'hE4);
        chk("asr_done", 32'(done), 32'h1);
        issue(3'b001, 0, 8'h00);
        chk("shr0_q", 32'(q), 32'hE4);
        chk("shr0_done", 32'(done), 32'h1);

        issue(3'b011, 0, 8'hB5);
        issue(3'b101, 4, 8'h00);
        cyc(); cyc(); cyc();
`ifdef USR_ROTATE_EN
        chk("ror_q", 32'(q), 32'h5B);
`else
        chk("ror_q", 32'(q), 32'hB5);
`endif
        chk("ror_done", 32'(done), 32'h1);

        issue(3'b011, 0, 8'hFF);
        ser_r = 1'b0;
        issue(3'b001, 5, 8'h00);
        cyc();
        rst_n = 1'b0;
        cyc();
        chk("midrst_q", 32'(q), 32'h00);
        chk("midrst_done", 32'(done), 32'h0);
        chk("midrst_ready", 32'(cmd_ready), 32'h1);
        rst_n = 1'b1;
        cyc();
        chk("midrst_nodone", 32'(done), 32'h0);
        issue(3'b011, 0, 8'h3C);
        chk("after_rst_load", 32'(q), 32'h3C);

        for (int i = 0; i < 3000; i++) begin
            rst_n     = ($urandom_range(0, 249) != 0);
            cmd_valid = ($urandom_range(0, 2) != 0);
            cmd_op    = 3'($urandom);
            cmd_cnt   = CW'($urandom_range(0, 11));
            cmd_pin   = W'($urandom);
            ser_r     = 1'($urandom);
            ser_l     = 1'($urandom);
            cyc();
        end
        cmd_valid = 1'b0;
        rst_n = 1'b1;
        cyc();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/uni_shift_reg_seq.md
# uni_shift_reg_seq

Parametrised, command-driven successor to the 4-bit universal shift register. It holds a WIDTH-bit register and executes multi-step shift, rotate, load and clear commands accepted over a valid/ready handshake. A counter FSM performs one bit-step per clock and reports completion with a one-cycle done pulse. The block sits between a control sequencer and serial/parallel datapaths that need N-bit shifts without per-cycle mode steering.

## Interface
- WIDTH, 8, register width; legal range ≥2.
- CNT_W, $clog2(WIDTH)+1, width of the step-count field; derived, do not override.
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous, active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  block can accept a command; high only in IDLE.
- cmd_op  in  3  operation code (see Operation).
- cmd_cnt  in  CNT_W  number of bit-steps for shift/rotate ops.
- cmd_pin  in  WIDTH  parallel load value.
- ser_r  in  1  serial input entering the MSB on a right shift.
- ser_l  in  1  serial input entering the LSB on a left shift.
- q  out  WIDTH  register contents.
- so_l  out  1  q[WIDTH-1] (combinational).
- so_r  out  1  q[0] (combinational).
- busy  out  1  multi-step command in progress.
- done  out  1  one-cycle pulse after the command's final update.

## Operation
- Op codes:
  - 000 HOLD
  - 001 SHR: q <= {ser_r, q[W-1:1]}
  - 010 SHL: q <= {q[W-2:0], ser_l}
  - 011 LOAD: q <= cmd_pin
  - 100 ASR: q <= {q[W-1], q[W-1:1]}
  - 101 ROR: q <= {q[0], q[W-1:1]}
  - 110 ROL: q <= {q[W-2:0], q[W-1]}
  - 111 CLEAR: q <= 0
- Handshake: a command is accepted on a rising edge where cmd_valid && cmd_ready. cmd_ready = (state == IDLE). While busy, cmd_valid is ignored and no input is captured.
- FSM states:
  - IDLE: on accept, perform the first step at the accept edge.
    - HOLD, LOAD, CLEAR: single-cycle, always; cmd_cnt is ignored.
    - Shift/rotate with cmd_cnt == 0: q is unchanged.
    - Shift/rotate with cmd_cnt == 1: one step.
    - Shift/rotate with cmd_cnt ≥ 2: one step, rem <= cmd_cnt-1, latch op, go to SHIFT.
  - SHIFT: one step per clock using the latched op; rem decrements each step; on the step where rem == 1, return to IDLE.
- done is registered. It is high for exactly one cycle following the edge that completes the command, including zero-count and single-cycle ops.
- Serial inputs ser_r and ser_l are sampled live on every step edge, not latched at accept.
- cmd_cnt > WIDTH is legal. Shifts fully flush to serial fill; rotates wrap modulo WIDTH by repetition.
- Reset (rst_n low at an edge), including mid-command:
  - q = 0, state IDLE, rem = 0, busy = 0, done = 0, cmd_ready = 1.
  - The pending command is discarded and no done is produced.

## Timing
- Accept at edge k with count N ≥ 1: q updates at edges k through k+N-1.
- busy is high in the cycles after edges k through k+N-2 (not asserted when N ≤ 1).
- done is high in the cycle after edge k+N-1; cmd_ready is high in that same cycle.
- Back-to-back: a new command may be accepted in the cycle that done is high.
- so_l and so_r follow q combinationally, with zero latency.

## Configuration
- USR_ROTATE_EN defined: ROR and ROL behave as specified.
- USR_ROTATE_EN undefined:
  - Op codes 101 and 110 execute as HOLD for the full count (q unchanged, busy and done timing identical).
  - The rotate datapath is not synthesised.

## Structure
- Package usr_pkg:
  - op-code enum (usr_op_t) with all eight encodings;
  - FSM state enum (usr_state_t: IDLE, SHIFT).
- Sub-module usr_step: purely combinational next-value function (op, q, ser_r, ser_l, cmd_pin) -> q_next, parametrised on WIDTH. The rotate branch is under USR_ROTATE_EN.
- The top level contains the FSM, the rem counter, the latched op, q, and done/busy.

## Test plan
- Reset with WIDTH=8: hold rst_n=0 for 2 cycles -> q=0x00, busy=0, done=0, cmd_ready=1.
- LOAD cmd_pin=0xB5 -> q=0xB5 at the accept edge; done=1 for one cycle; busy never asserted.
- From q=0xB5: SHL cnt=3 with ser_l=1 -> q=0x6B, 0xD7, 0xAF on successive edges; busy high 2 cycles; then done pulse; cmd_valid asserted while busy is ignored.
- From q=0x90: ASR cnt=2 -> q=0xC8 then 0xE4; done pulse; then SHR cnt=0 -> q stays 0xE4 and done pulses next cycle.
- From q=0xB5: ROR cnt=4 -> q=0x5B with USR_ROTATE_EN. Without the macro -> q stays 0xB5 and done still pulses after 4 steps.
- From q=0xFF: SHR cnt=5 with ser_r=0; drive rst_n=0 at the third step edge -> q=0x00, IDLE, no done pulse. Next LOAD 0x3C is accepted normally.
